// File: rtl/clint_arb.sv
// clint_arb: core-local interrupt arbiter and trap/return sequencer.
// Decodes ecall/ebreak/mret from ID and arbitrates the level interrupt lines.
// It then writes mepc/mcause/mstatus one CSR per cycle and redirects EX.
// Optional macro CLINT_VECTORED_EN enables vectored async trap targets
// when mtvec[1:0]==2'b01.
module clint_arb #(
   parameter int NUM_IRQ        = 4,
   parameter int IRQ_CAUSE_BASE = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_IRQ-1:0] irq_i,
   input  logic [NUM_IRQ-1:0] irq_en_i,
   input  logic               hold_i,
   input  logic [31:0]        inst_i,
   input  logic [31:0]        inst_addr_i,
   input  logic [31:0]        csr_mtvec,
   input  logic [31:0]        csr_mepc,
   input  logic [31:0]        csr_mstatus,
   output logic               hold_o,
   output logic               csr_we_o,
   output logic [31:0]        csr_waddr_o,
   output logic [31:0]        csr_wdata_o,
   output logic               int_assert_o,
   output logic [31:0]        int_addr_o,
   output logic [NUM_IRQ-1:0] irq_ack_o
);

   localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

   localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
   localparam logic [31:0] INST_MRET   = 32'h3020_0073;

   localparam logic [31:0] CSR_MSTATUS = 32'h300;
   localparam logic [31:0] CSR_MEPC    = 32'h341;
   localparam logic [31:0] CSR_MCAUSE  = 32'h342;

   typedef enum logic [2:0] {
      S_IDLE, S_MEPC, S_MCAUSE, S_MSTATUS, S_TRAP, S_MRET, S_RET
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        pc_q, cause_q;
   logic [IDX_W-1:0]   idx_q;
   logic               async_q;

   logic [NUM_IRQ-1:0] pending;
   logic [IDX_W-1:0]   win_idx;
   logic               irq_take;
   logic               trap_ev;
   logic               mret_ev;
   logic               ev_async;
   logic [31:0]        ev_cause;
   logic               capture;
   logic [31:0]        trap_base;

   assign pending   = irq_i & irq_en_i;
   assign irq_take  = (|pending) & csr_mstatus[3];
   assign trap_base = csr_mtvec & 32'hFFFF_FFFC;

   // Lowest-index pending line wins the async arbitration.
   always_comb begin
      // NOTE: every variable gets a default first so no latch is inferred.
      win_idx = '0;
      for (int k = NUM_IRQ - 1; k >= 0; k--) begin
         if (pending[k]) win_idx = IDX_W'(k);
      end
   end

   // Prioritised event decode: ecall, ebreak, enabled irq, then mret.
   always_comb begin
      trap_ev  = 1'b0;
      mret_ev  = 1'b0;
      ev_async = 1'b0;
      ev_cause = '0;
      if (inst_i == INST_ECALL) begin
         trap_ev  = 1'b1;
         ev_cause = 32'd11;
      end else if (inst_i == INST_EBREAK) begin
         trap_ev  = 1'b1;
         ev_cause = 32'd3;
      end else if (irq_take) begin
         trap_ev  = 1'b1;
         ev_async = 1'b1;
         ev_cause = 32'h8000_0000 | (32'(IRQ_CAUSE_BASE) + 32'(win_idx));
      end else if (inst_i == INST_MRET) begin
         mret_ev = 1'b1;
      end
   end

   // Next-state logic: events are only accepted in IDLE with the pipeline free.
   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!hold_i && trap_ev) begin
               state_d = S_MEPC;
               capture = 1'b1;
            end else if (!hold_i && mret_ev) begin
               state_d = S_MRET;
            end
         end
         S_MEPC:    state_d = S_MCAUSE;
         S_MCAUSE:  state_d = S_MSTATUS;
         S_MSTATUS: state_d = S_TRAP;
         S_MRET:    state_d = S_RET;
         default:   state_d = S_IDLE;
      endcase
   end

   // State register and the trap context latched when an event is taken.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments for all registered state.
      if (rst) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         cause_q <= '0;
         idx_q   <= '0;
         async_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (capture) begin
            pc_q    <= inst_addr_i;
            cause_q <= ev_cause;
            idx_q   <= win_idx;
            async_q <= ev_async;
         end
      end
   end

   // Stall ctrl while sequencing, and in the very cycle an event is accepted.
   assign hold_o = (state_q != S_IDLE) | (!hold_i & (trap_ev | mret_ev));

   // Moore output decode: CSR writes, redirect and acknowledge per state.
   always_comb begin
      csr_we_o     = 1'b0;
      csr_waddr_o  = '0;
      csr_wdata_o  = '0;
      int_assert_o = 1'b0;
      int_addr_o   = '0;
      irq_ack_o    = '0;
      case (state_q)
         S_MEPC: begin
            csr_we_o    = 1'b1;
            csr_waddr_o = CSR_MEPC;
            csr_wdata_o = pc_q;
         end
         S_MCAUSE: begin
            csr_we_o    = 1'b1;
            csr_waddr_o = CSR_MCAUSE;
            csr_wdata_o = cause_q;
         end
         S_MSTATUS: begin
            csr_we_o       = 1'b1;
            csr_waddr_o    = CSR_MSTATUS;
            csr_wdata_o    = csr_mstatus;
            csr_wdata_o[7] = csr_mstatus[3];
            csr_wdata_o[3] = 1'b0;
         end
         S_TRAP: begin
            int_assert_o = 1'b1;
            int_addr_o   = trap_base;
`ifdef CLINT_VECTORED_EN
            // cause_q low bits hold IRQ_CAUSE_BASE+k; shifting by two gives 4*(base+k).
            if (async_q && csr_mtvec[1:0] == 2'b01)
               int_addr_o = trap_base + {cause_q[29:0], 2'b00};
`endif
            for (int k = 0; k < NUM_IRQ; k++)
               irq_ack_o[k] = async_q && (idx_q == IDX_W'(k));
         end
         S_MRET: begin
            csr_we_o       = 1'b1;
            csr_waddr_o    = CSR_MSTATUS;
            csr_wdata_o    = csr_mstatus;
            csr_wdata_o[3] = csr_mstatus[7];
            csr_wdata_o[7] = 1'b1;
         end
         S_RET: begin
            int_assert_o = 1'b1;
            int_addr_o   = csr_mepc;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_clint_arb.sv
// tb_clint_arb: directed test-plan scenarios plus randomized stimulus for
// clint_arb, checked every cycle against a script-based reference model.
module tb_clint_arb;

   localparam int NI = 4;
   localparam int CB = 16;

   localparam logic [31:0] ECALL  = 32'h0000_0073;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] MRET   = 32'h3020_0073;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic          clk = 1'b0;
   logic          rst;
   logic [NI-1:0] irq_i, irq_en_i;
   logic          hold_i;
   logic [31:0]   inst_i, inst_addr_i, csr_mtvec, csr_mepc, csr_mstatus;
   logic          hold_o, csr_we_o, int_assert_o;
   logic [31:0]   csr_waddr_o, csr_wdata_o, int_addr_o;
   logic [NI-1:0] irq_ack_o;

   int n_checks = 0;
   int n_errors = 0;

   clint_arb #(.NUM_IRQ(NI), .IRQ_CAUSE_BASE(CB)) dut (
      .clk(clk), .rst(rst), .irq_i(irq_i), .irq_en_i(irq_en_i), .hold_i(hold_i),
      .inst_i(inst_i), .inst_addr_i(inst_addr_i), .csr_mtvec(csr_mtvec),
      .csr_mepc(csr_mepc), .csr_mstatus(csr_mstatus), .hold_o(hold_o),
      .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
      .int_assert_o(int_assert_o), .int_addr_o(int_addr_o), .irq_ack_o(irq_ack_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: an accepted event appends the list of per-cycle actions
   // it must produce; each following cycle consumes one action.
   typedef enum {K_MEPC, K_MCAUSE, K_MSTATUS, K_TRAP, K_MRET, K_RET} kind_e;
   typedef struct {
      kind_e       kind;
      logic [31:0] pc;
      logic [31:0] cause;
      int          idx;
      bit          is_async;
   } act_t;

   act_t script[$];

   task automatic push_act(input kind_e k, input logic [31:0] pc, input logic [31:0] cause,
                           input int idx, input bit is_async);
      act_t a;
      a.kind = k; a.pc = pc; a.cause = cause; a.idx = idx; a.is_async = is_async;
      script.push_back(a);
   endtask

   task automatic settle_check();
      act_t          a;
      logic          e_hold, e_we, e_assert;
      logic [31:0]   e_waddr, e_wdata, e_addr;
      logic [NI-1:0] e_ack;
      logic [NI-1:0] pend;
      int            widx;
      #1;
      e_hold = 1'b0; e_we = 1'b0; e_assert = 1'b0;
      e_waddr = '0; e_wdata = '0; e_addr = '0; e_ack = '0;
      if (script.size() > 0) begin
         a = script.pop_front();
         e_hold = 1'b1;
         case (a.kind)
            K_MEPC:    begin e_we = 1; e_waddr = 32'h341; e_wdata = a.pc; end
            K_MCAUSE:  begin e_we = 1; e_waddr = 32'h342; e_wdata = a.cause; end
            K_MSTATUS: begin
               e_we = 1; e_waddr = 32'h300;
               e_wdata = (csr_mstatus & ~32'h88) | (csr_mstatus[3] ? 32'h80 : 32'h0);
            end
            K_TRAP: begin
               e_assert = 1;
               e_addr = {csr_mtvec[31:2], 2'b00};
`ifdef CLINT_VECTORED_EN
               if (a.is_async && csr_mtvec[1:0] == 2'b01) e_addr = e_addr + 32'(4 * (CB + a.idx));
`endif
               if (a.is_async) e_ack = NI'(1 << a.idx);
            end
            K_MRET: begin
               e_we = 1; e_waddr = 32'h300;
               e_wdata = (csr_mstatus & ~32'h88) | 32'h80 | (csr_mstatus[7] ? 32'h8 : 32'h0);
            end
            K_RET: begin e_assert = 1; e_addr = csr_mepc; end
            default: ;
         endcase
      end else if (!hold_i) begin
         pend = irq_i & irq_en_i;
         widx = -1;
         for (int k = 0; k < NI; k++) if (pend[k] && widx < 0) widx = k;
         if (inst_i == ECALL || inst_i == EBREAK || (widx >= 0 && csr_mstatus[3])) begin
            logic [31:0] c;
            bit          asy;
            asy = !(inst_i == ECALL || inst_i == EBREAK);
            c = (inst_i == ECALL) ? 32'd11 : (inst_i == EBREAK) ? 32'd3
              : (32'h8000_0000 + 32'(CB + widx));
            e_hold = 1'b1;
            push_act(K_MEPC,    inst_addr_i, c, widx, asy);
            push_act(K_MCAUSE,  inst_addr_i, c, widx, asy);
            push_act(K_MSTATUS, inst_addr_i, c, widx, asy);
            push_act(K_TRAP,    inst_addr_i, c, widx, asy);
         end else if (inst_i == MRET) begin
            e_hold = 1'b1;
            push_act(K_MRET, '0, '0, 0, 0);
            push_act(K_RET,  '0, '0, 0, 0);
         end
      end
      check("hold_o",       32'(hold_o),       32'(e_hold));
      check("csr_we_o",     32'(csr_we_o),     32'(e_we));
      check("csr_waddr_o",  csr_waddr_o,       e_waddr);
      check("csr_wdata_o",  csr_wdata_o,       e_wdata);
      check("int_assert_o", 32'(int_assert_o), 32'(e_assert));
      check("int_addr_o",   int_addr_o,        e_addr);
      check("irq_ack_o",    32'(irq_ack_o),    32'(e_ack));
      if (rst) script.delete();
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic quiet();
      rst = 0; inst_i = NOP; irq_i = '0; irq_en_i = '0; hold_i = 0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin settle_check(); tick(); end
   endtask

   initial begin
      quiet();
      rst = 1; inst_addr_i = '0; csr_mtvec = '0; csr_mepc = '0; csr_mstatus = '0;
      tick();
      settle_check();
      check("reset_hold", 32'(hold_o), 32'd0);
      check("reset_we",   32'(csr_we_o), 32'd0);
      tick();
      rst = 0;
      idle_cycles(2);

      // ecall at 0x100, mtvec 0x200, MIE=1
      quiet(); inst_addr_i = 32'h100; csr_mtvec = 32'h200; csr_mstatus = 32'h8; inst_i = ECALL;
      settle_check(); check("ecall_hold", 32'(hold_o), 32'd1); tick();
      inst_i = NOP;
      settle_check(); check("ecall_mepc_addr", csr_waddr_o, 32'h341);
      check("ecall_mepc_data", csr_wdata_o, 32'h100); tick();
      settle_check(); check("ecall_mcause_addr", csr_waddr_o, 32'h342);
      check("ecall_mcause_data", csr_wdata_o, 32'd11); tick();
      settle_check(); check("ecall_mstatus_addr", csr_waddr_o, 32'h300);
      check("ecall_mstatus_data", csr_wdata_o, 32'h80); tick();
      settle_check(); check("ecall_redirect", 32'(int_assert_o), 32'd1);
      check("ecall_target", int_addr_o, 32'h200); tick();
      settle_check(); check("ecall_idle_hold", 32'(hold_o), 32'd0); tick();

      // irq lines 1 and 2 pending, line 1 wins; irq drops mid-sequence
      quiet(); csr_mstatus = 32'h8; irq_i = 4'b0110; irq_en_i = 4'b1111; inst_addr_i = 32'h40;
      settle_check(); tick();
      irq_i = '0;
      settle_check(); tick();
      settle_check(); check("irq_mcause", csr_wdata_o, 32'h8000_0011); tick();
      settle_check(); tick();
      settle_check(); check("irq_ack", 32'(irq_ack_o), 32'h2); tick();
      idle_cycles(1);

      // masked interrupts: MIE=0, then irq_en_i=0
      quiet(); csr_mstatus = 32'h0; irq_i = 4'b0110; irq_en_i = 4'b1111;
      settle_check(); check("mie0_hold", 32'(hold_o), 32'd0); tick();
      settle_check(); check("mie0_we", 32'(csr_we_o), 32'd0); tick();
      csr_mstatus = 32'h8; irq_en_i = '0;
      settle_check(); check("en0_hold", 32'(hold_o), 32'd0); tick();
      settle_check(); check("en0_we", 32'(csr_we_o), 32'd0); tick();

      // hold_i blocks an ecall until released
      quiet(); inst_i = ECALL; hold_i = 1;
      settle_check(); check("held_hold", 32'(hold_o), 32'd0); tick();
      settle_check(); check("held_we", 32'(csr_we_o), 32'd0); tick();
      hold_i = 0;
      settle_check(); check("released_hold", 32'(hold_o), 32'd1); tick();
      inst_i = NOP;
      idle_cycles(5);

      // mret with mstatus 0x80, mepc 0x104
      quiet(); csr_mstatus = 32'h80; csr_mepc = 32'h104; inst_i = MRET;
      settle_check(); check("mret_hold", 32'(hold_o), 32'd1); tick();
      inst_i = NOP;
      settle_check(); check("mret_addr", csr_waddr_o, 32'h300);
      check("mret_data", csr_wdata_o, 32'h88); tick();
      settle_check(); check("mret_redirect", 32'(int_assert_o), 32'd1);
      check("mret_target", int_addr_o, 32'h104); tick();
      idle_cycles(1);

      // vectored mtvec with irq line 2
      quiet(); csr_mtvec = 32'h201; csr_mstatus = 32'h8; irq_i = 4'b0100; irq_en_i = 4'b1111;
      settle_check(); tick();
      irq_i = '0;
      idle_cycles(3);
      settle_check();
`ifdef CLINT_VECTORED_EN
      check("vector_target", int_addr_o, 32'h248);
`else
      check("vector_target", int_addr_o, 32'h200);
`endif
      check("vector_ack", 32'(irq_ack_o), 32'h4); tick();
      idle_cycles(1);

      // reset pulse while in MCAUSE aborts the sequence
      quiet(); csr_mtvec = 32'h200; inst_i = ECALL;
      settle_check(); tick();
      inst_i = NOP;
      settle_check(); tick();
      rst = 1;
      settle_check(); check("rst_in_mcause", csr_waddr_o, 32'h342); tick();
      rst = 0;
      for (int i = 0; i < 4; i++) begin
         settle_check();
         check("post_rst_we", 32'(csr_we_o), 32'd0);
         check("post_rst_redirect", 32'(int_assert_o), 32'd0);
         check("post_rst_ack", 32'(irq_ack_o), 32'd0);
         tick();
      end

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         int r;
         r = $urandom_range(0, 9);
         inst_i = (r < 2) ? ECALL : (r == 2) ? EBREAK : (r == 3) ? MRET
                : (r == 4) ? 32'($urandom) : NOP;
         irq_i       = ($urandom_range(0, 2) == 0) ? NI'($urandom) : '0;
         irq_en_i    = NI'($urandom);
         hold_i      = ($urandom_range(0, 3) == 0);
         csr_mstatus = $urandom;
         csr_mtvec   = $urandom;
         csr_mepc    = $urandom;
         inst_addr_i = $urandom;
         rst         = ($urandom_range(0, 99) == 0);
         settle_check();
         tick();
      end

      quiet();
      idle_cycles(8);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
